// File: rtl/mmio_bus_decoder.sv
// rtl/mmio_bus_decoder.sv - registered MMIO address decoder with chip selects, ack wait, timeout and error capture
module mmio_bus_decoder #(
    parameter int                    NUM_SLV  = 5,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'hFFFF_3000, 32'hFFFF_2000, 32'hFFFF_1000,
                                                 32'hFFFF_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
                                                 32'hFFFF_F000, 32'hFFFF_E000},
    parameter int                    TIMEOUT  = 16,
    parameter int                    CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [31:0]           cpu_addr,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic [31:0]           cpu_rdata,
    output logic [NUM_SLV-1:0]    cs_n,
    input  logic [NUM_SLV-1:0]    slv_ack,
    input  logic [NUM_SLV*32-1:0] slv_rdata,
    output logic                  err_flag,
    output logic [31:0]           err_addr,
    input  logic                  err_clr
);

    localparam int                SEL_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_SLV-1:0] CS_IDLE = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   sel_q;
    logic [31:0]        addr_q;

    logic               hit;
    logic [SEL_W-1:0]   sel;
    logic [31:0]        rdata_arr [NUM_SLV];
    logic               err_entry;
    logic [31:0]        err_src_addr;

    // Window match; scanning from the top down lets the lowest matching slot win.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((cpu_addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

    // Unpack the per-slave read data bus so it can be indexed by the latched select.
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            rdata_arr[i] = slv_rdata[32*i +: 32];
        end
    end

    // Flags the cycle in which the FSM will enter RESP with an error, and which address caused it.
    always_comb begin
        err_entry    = 1'b0;
        err_src_addr = addr_q;
        if (state == ST_IDLE) begin
            err_entry    = cpu_req && !hit;
            err_src_addr = cpu_addr;
        end else if (state == ST_ACCESS) begin
            err_entry    = !slv_ack[sel_q] && (cnt == TMO_LAST);
        end
    end

    // Access FSM: decode in IDLE, hold the chip select through ACCESS, one-cycle response in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            cs_n      <= CS_IDLE;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (hit) begin
                            addr_q <= cpu_addr;
                            sel_q  <= sel;
                            cs_n   <= ~(NUM_SLV'(1) << sel);
                            cnt    <= '0;
                            state  <= ST_ACCESS;
                        end else begin
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // A late acknowledge on the last timeout cycle still completes the access.
                    if (slv_ack[sel_q]) begin
                        cs_n      <= CS_IDLE;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= rdata_arr[sel_q];
                        state     <= ST_RESP;
                    end else if (cnt == TMO_LAST) begin
                        cs_n    <= CS_IDLE;
                        cpu_ack <= 1'b1;
                        cpu_err <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    cs_n  <= CS_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error capture: keep the first failing address; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (err_entry) begin
            err_flag <= 1'b1;
            if (!err_flag || err_clr) begin
                err_addr <= err_src_addr;
            end
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end
    end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// tb/tb_mmio_bus_decoder.sv - directed self-checking bench for mmio_bus_decoder
module tb_mmio_bus_decoder;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ack;
    logic         cpu_err;
    logic [31:0]  cpu_rdata;
    logic [4:0]   cs_n;
    logic [4:0]   slv_ack;
    logic [159:0] slv_rdata;
    logic         err_flag;
    logic [31:0]  err_addr;
    logic         err_clr;

    int tests_run;
    int tests_failed;

    mmio_bus_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .cs_n      (cs_n),
        .slv_ack   (slv_ack),
        .slv_rdata (slv_rdata),
        .err_flag  (err_flag),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        slv_ack   = '0;
        err_clr   = 1'b0;
        slv_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

        tick();
        tick();
        check("rst_cs_n",     32'(cs_n),      32'h1F);
        check("rst_ack",      32'(cpu_ack),   32'h0);
        check("rst_err",      32'(cpu_err),   32'h0);
        check("rst_rdata",    cpu_rdata,      32'h0);
        check("rst_err_flag", 32'(err_flag),  32'h0);
        check("rst_err_addr", err_addr,       32'h0);
        reset = 1'b0;
        tick();

        // Read from memory window, ack one cycle after cs_n falls
        cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
        tick();
        cpu_req = 1'b0;
        check("t1_cs_low", 32'(cs_n),    32'h1E);
        check("t1_no_ack", 32'(cpu_ack), 32'h0);
        slv_ack = 5'b00001;
        tick();
        slv_ack = '0;
        check("t1_ack",   32'(cpu_ack), 32'h1);
        check("t1_err",   32'(cpu_err), 32'h0);
        check("t1_rdata", cpu_rdata,    32'h1234_5678);
        check("t1_cs_hi", 32'(cs_n),    32'h1F);
        tick();
        check("t1_ack_drop",   32'(cpu_ack), 32'h0);
        check("t1_rdata_zero", cpu_rdata,    32'h0);

        // GPIO with three wait cycles and stray acks from slot 1
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_2004;
        tick();
        cpu_req = 1'b0;
        check("t2_cs_low", 32'(cs_n), 32'h17);
        for (int k = 0; k < 3; k++) begin
            slv_ack = (k == 1) ? 5'b00000 : 5'b00010;
            tick();
            check("t2_cs_wait",  32'(cs_n),    32'h17);
            check("t2_ack_wait", 32'(cpu_ack), 32'h0);
        end
        slv_ack = 5'b01000;
        tick();
        slv_ack = '0;
        check("t2_ack",   32'(cpu_ack), 32'h1);
        check("t2_err",   32'(cpu_err), 32'h0);
        check("t2_rdata", cpu_rdata,    32'h3333_3333);
        check("t2_cs_hi", 32'(cs_n),    32'h1F);
        tick();

        // Unmapped access
        cpu_req = 1'b1; cpu_addr = 32'h8000_0000;
        tick();
        cpu_req = 1'b0;
        check("t3_ack",      32'(cpu_ack),  32'h1);
        check("t3_err",      32'(cpu_err),  32'h1);
        check("t3_rdata",    cpu_rdata,     32'h0);
        check("t3_cs",       32'(cs_n),     32'h1F);
        check("t3_err_flag", 32'(err_flag), 32'h1);
        check("t3_err_addr", err_addr,      32'h8000_0000);
        tick();

        // Timeout on slot 2: 16 cycles of cs_n low, then error
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_1000;
        tick();
        cpu_req = 1'b0;
        check("t4_cs_low", 32'(cs_n), 32'h1B);
        for (int k = 0; k < 15; k++) begin
            tick();
            check("t4_cs_wait",  32'(cs_n),    32'h1B);
            check("t4_ack_wait", 32'(cpu_ack), 32'h0);
        end
        tick();
        check("t4_ack",       32'(cpu_ack),  32'h1);
        check("t4_err",       32'(cpu_err),  32'h1);
        check("t4_rdata",     cpu_rdata,     32'h0);
        check("t4_cs_hi",     32'(cs_n),     32'h1F);
        check("t4_err_flag",  32'(err_flag), 32'h1);
        check("t4_first_err", err_addr,      32'h8000_0000);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_clr_flag", 32'(err_flag), 32'h0);
        check("t4_clr_addr", err_addr,      32'h0);

        // Ack on the 16th cycle beats the timeout
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_1000;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        check("t4b_cs_last", 32'(cs_n), 32'h1B);
        slv_ack = 5'b00100;
        tick();
        slv_ack = '0;
        check("t4b_ack",      32'(cpu_ack),  32'h1);
        check("t4b_err",      32'(cpu_err),  32'h0);
        check("t4b_rdata",    cpu_rdata,     32'h2222_2222);
        check("t4b_err_flag", 32'(err_flag), 32'h0);
        tick();

        // Reset during an access to slot 4
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_3000;
        tick();
        cpu_req = 1'b0;
        check("t5_cs_low", 32'(cs_n), 32'h0F);
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_cs",  32'(cs_n),    32'h1F);
        check("t5_rst_ack", 32'(cpu_ack), 32'h0);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_3000;
        tick();
        cpu_req = 1'b0;
        check("t5_new_cs",  32'(cs_n),    32'h0F);
        check("t5_new_ack", 32'(cpu_ack), 32'h0);
        slv_ack = 5'b10000;
        tick();
        slv_ack = '0;
        check("t5_new_done",  32'(cpu_ack), 32'h1);
        check("t5_new_rdata", cpu_rdata,    32'h4444_4444);
        tick();

        // Top of slot 0 still hits
        cpu_req = 1'b1; cpu_addr = 32'h0000_1FFC;
        tick();
        cpu_req = 1'b0;
        check("t6_edge_cs", 32'(cs_n), 32'h1E);
        slv_ack = 5'b00001;
        tick();
        slv_ack = '0;
        check("t6_edge_rdata", cpu_rdata, 32'h1234_5678);
        tick();

        // Error coinciding with err_clr: new error wins and reloads err_addr
        cpu_req = 1'b1; cpu_addr = 32'h8000_0000;
        tick();
        cpu_req = 1'b0;
        check("t7_first_addr", err_addr, 32'h8000_0000);
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h0000_2000; err_clr = 1'b1;
        tick();
        cpu_req = 1'b0; err_clr = 1'b0;
        check("t7_err",      32'(cpu_err),  32'h1);
        check("t7_cs",       32'(cs_n),     32'h1F);
        check("t7_err_flag", 32'(err_flag), 32'h1);
        check("t7_err_addr", err_addr,      32'h0000_2000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
